button_tick_gen: RTL and testbench

BUTTON_TICK_GEN -- requirements
Module: button_tick_gen

---
 rtl/button_tick_gen.sv | 143 ++++++++++++++
 tb/tb_button_tick_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_tick_gen.sv
// Debounces four push-buttons and turns "any button held" into a single-cycle
// step pulse with a long initial hold delay followed by periodic auto-repeat.
module button_tick_gen #(
  parameter int DB_CYCLES     = 500000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic tick_cycle
);

  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DB_CYCLES - 1);
  localparam logic [TW-1:0]   HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]   REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_e;

  // Bit order everywhere: [0]=up, [1]=down, [2]=left, [3]=right
  logic [3:0] rawBtn;
  logic [3:0] syncA_q, syncB_q;
  logic [3:0] stable_q, stable_d;
  logic [3:0] level_q;
  logic [DB_W-1:0] debCnt_q [4];
  logic [DB_W-1:0] debCnt_d [4];

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          tick_q, tick_d;
  logic          anyHeld;

  assign rawBtn = {btn_right, btn_left, btn_down, btn_up};

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      debCnt_d[i] = '0;
      if (syncB_q[i] != stable_q[i]) begin
        if (debCnt_q[i] == DB_LAST) begin
          stable_d[i] = syncB_q[i];
        end else begin
          debCnt_d[i] = debCnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syncA_q  <= '0;
      syncB_q  <= '0;
      stable_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        debCnt_q[i] <= '0;
      end
    end else begin
      syncA_q  <= rawBtn;
      syncB_q  <= syncA_q;
      stable_q <= stable_d;
      level_q  <= stable_q;
      for (int i = 0; i < 4; i++) begin
        debCnt_q[i] <= debCnt_d[i];
      end
    end
  end

  // Release is tested before the timer so a due tick is dropped when any falls
  assign anyHeld = |level_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    tick_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (anyHeld) begin
          tick_d  = 1'b1;
          timer_d = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!anyHeld) begin
          timer_d = '0;
          state_d = IDLE;
        end else if (timer_q == HOLD_LAST) begin
          tick_d  = 1'b1;
          timer_d = '0;
          state_d = REPEAT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      REPEAT: begin
        if (!anyHeld) begin
          timer_d = '0;
          state_d = IDLE;
        end else if (timer_q == REPEAT_LAST) begin
          tick_d  = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      tick_q  <= tick_d;
    end
  end

  assign up         = level_q[0];
  assign down       = level_q[1];
  assign left       = level_q[2];
  assign right      = level_q[3];
  assign tick_cycle = tick_q;

endmodule

// File: tb/tb_button_tick_gen.sv
// Directed bench for button_tick_gen with short debounce/hold/repeat periods;
// tick times are logged relative to the clock on which stimulus was applied.
module tb_button_tick_gen;

  localparam int DB  = 4;
  localparam int HLD = 20;
  localparam int REP = 5;

  logic clk;
  logic rst;
  logic btnUp, btnDown, btnLeft, btnRight;
  logic up, down, left, right, tickCycle;

  int checkCount  = 0;
  int errorCount  = 0;
  int cyc         = 0;
  int doubleTicks = 0;
  int base;
  int highSeen;
  logic prevTick  = 1'b0;
  int tickLog[$];
  logic [3:0] tickLvl[$];
  int expQ[$];

  button_tick_gen #(
    .DB_CYCLES    (DB),
    .HOLD_CYCLES  (HLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btnUp),
    .btn_down  (btnDown),
    .btn_left  (btnLeft),
    .btn_right (btnRight),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .tick_cycle(tickCycle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Buttons packed as {up, down, left, right}
  task automatic applyStimulus(input logic [3:0] btns);
    btnUp    = btns[3];
    btnDown  = btns[2];
    btnLeft  = btns[1];
    btnRight = btns[0];
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
    cyc++;
    if (tickCycle === 1'b1) begin
      if (prevTick) doubleTicks++;
      tickLog.push_back(cyc);
      tickLvl.push_back({up, down, left, right});
    end
    prevTick = tickCycle;
  endtask

  task automatic runCycles(input int n);
    repeat (n) stepClk();
  endtask

  task automatic clearLog();
    tickLog.delete();
    tickLvl.delete();
  endtask

  task automatic checkTicks(input string tag, input int origin, input int expOff[$]);
    int got;
    checkOutput({tag, "_count"}, tickLog.size(), expOff.size());
    for (int i = 0; i < expOff.size(); i++) begin
      got = (i < tickLog.size()) ? tickLog[i] - origin : -1;
      checkOutput($sformatf("%s_tick%0d", tag, i), got, expOff[i]);
    end
  endtask

  function automatic int lvlAt(input int i);
    return (i < tickLvl.size()) ? int'(tickLvl[i]) : -1;
  endfunction

  initial begin
    rst = 1'b0;
    applyStimulus(4'b0000);
    runCycles(2);
    checkOutput("reset_levels", int'({up, down, left, right}), 0);
    checkOutput("reset_tick", int'(tickCycle), 0);
    rst = 1'b1;
    stepClk();
    checkOutput("first_clk_no_tick", int'(tickCycle), 0);
    runCycles(3);

    $display("[TB] clean press on right");
    clearLog();
    applyStimulus(4'b0001);
    base = cyc;
    runCycles(6);
    checkOutput("right_before_rise", int'(right), 0);
    stepClk();
    checkOutput("right_rise", int'(right), 1);
    checkOutput("no_tick_on_rise", int'(tickCycle), 0);
    stepClk();
    checkOutput("press_tick", int'(tickCycle), 1);
    stepClk();
    checkOutput("press_tick_end", int'(tickCycle), 0);
    applyStimulus(4'b0000);
    runCycles(20);
    checkOutput("right_released", int'(right), 0);
    expQ.delete(); expQ.push_back(8);
    checkTicks("press", base, expQ);

    $display("[TB] bouncing up");
    clearLog();
    highSeen = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus({(k % 2 == 0), 3'b000});
      for (int j = 0; j < 2; j++) begin
        stepClk();
        if (up) highSeen++;
      end
    end
    applyStimulus(4'b1000);
    base = cyc;
    for (int j = 0; j < 6; j++) begin
      stepClk();
      if (up) highSeen++;
    end
    checkOutput("bounce_no_glitch", highSeen, 0);
    stepClk();
    checkOutput("bounce_up_rise", int'(up), 1);
    runCycles(5);
    applyStimulus(4'b0000);
    runCycles(20);
    expQ.delete(); expQ.push_back(8);
    checkTicks("bounce", base, expQ);

    $display("[TB] auto-repeat on down");
    clearLog();
    applyStimulus(4'b0100);
    base = cyc;
    runCycles(100);
    expQ.delete(); expQ.push_back(8); expQ.push_back(28);
    for (int t = 33; t <= 98; t += 5) expQ.push_back(t);
    checkTicks("repeat", base, expQ);
    clearLog();
    applyStimulus(4'b0000);
    runCycles(20);
    checkOutput("down_released", int'(down), 0);
    expQ.delete(); expQ.push_back(103);
    checkTicks("repeat_release", base, expQ);

    $display("[TB] release exactly when a repeat tick is due");
    clearLog();
    applyStimulus(4'b0010);
    base = cyc;
    runCycles(30);
    applyStimulus(4'b0000);
    runCycles(6);
    checkOutput("left_still_high", int'(left), 1);
    stepClk();
    checkOutput("left_fell", int'(left), 0);
    stepClk();
    checkOutput("release_priority_tick", int'(tickCycle), 0);
    runCycles(30);
    expQ.delete(); expQ.push_back(8); expQ.push_back(28); expQ.push_back(33);
    checkTicks("release", base, expQ);

    $display("[TB] switch from up to left while held");
    clearLog();
    applyStimulus(4'b1000);
    base = cyc;
    runCycles(30);
    applyStimulus(4'b1010);
    runCycles(2);
    applyStimulus(4'b0010);
    runCycles(23);
    expQ.delete();
    expQ.push_back(8); expQ.push_back(28);
    for (int t = 33; t <= 53; t += 5) expQ.push_back(t);
    checkTicks("switch", base, expQ);
    checkOutput("switch_lvl_first", lvlAt(0), int'(4'b1000));
    checkOutput("switch_lvl_both", lvlAt(3), int'(4'b1010));
    checkOutput("switch_lvl_after", lvlAt(4), int'(4'b0010));
    checkOutput("switch_lvl_last", lvlAt(6), int'(4'b0010));

    $display("[TB] reset while repeating");
    clearLog();
    rst = 1'b0;
    #1;
    checkOutput("async_reset_left", int'(left), 0);
    checkOutput("async_reset_tick", int'(tickCycle), 0);
    runCycles(3);
    checkOutput("reset_hold_outputs", int'({up, down, left, right, tickCycle}), 0);
    rst = 1'b1;
    base = cyc;
    stepClk();
    checkOutput("post_reset_no_tick", int'(tickCycle), 0);
    runCycles(5);
    checkOutput("post_reset_left_low", int'(left), 0);
    stepClk();
    checkOutput("post_reset_left_high", int'(left), 1);
    stepClk();
    checkOutput("post_reset_tick", int'(tickCycle), 1);
    stepClk();
    applyStimulus(4'b0000);
    runCycles(15);
    expQ.delete(); expQ.push_back(8);
    checkTicks("post_reset", base, expQ);

    checkOutput("tick_width", doubleTicks, 0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
